sprite_compositor: RTL
======================

Name: sprite_compositor

Overview:
- Parametrised, pipelined pixel compositor for the game's video path. It replaces fixed per-object priority chains with N generic sprite layers, an overlay banner and a border/background generator.
- Owns the screen-mode state machine (TITLE/PLAY/WIN/LOSE). Mode changes are committed only at frame start, so no frame tears.
- Sits between the per-sprite display ROM modules and the VGA output stage, on the pixel clock.

Parameters:
- N_LAYERS, 8, number of sprite layers (player, homework, gold, platforms...); index 0 has highest priority
- XW, 11, width of the x coordinate
- YW, 10, width of the y coordinate
- SPR_W, 32, sprite width in pixels (hit region x in [lx, lx+SPR_W-1])
- SPR_H, 32, sprite height in pixels
- KEY_RGB, 12'h000, colour key; a layer pixel equal to it is transparent
- XMIN, 10 / XMAX, 1268 / YMIN, 10 / YMAX, 789: border limits
- BORDER_RGB, 12'h078, border colour
- PLAY_BG, 12'hEEE / TITLE_BG, 12'hFFF / WIN_BG, 12'hFFF / LOSE_BG, 12'h000: background colour per mode

Ports:
- clk_83  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at pixel (0,0)
- start  in  1  level; leave TITLE
- restart  in  1  pulse; leave WIN/LOSE
- win  in  1  level from game logic
- lose  in  1  level from game logic
- draw_x  in  XW  current pixel x
- draw_y  in  YW  current pixel y
- layer_x  in  N_LAYERS*XW  packed sprite left edges (layer i at [i*XW +: XW])
- layer_y  in  N_LAYERS*YW  packed sprite top edges
- layer_rgb  in  N_LAYERS*12  packed sprite pixel colours, valid for the same-cycle draw_x/draw_y
- layer_en  in  N_LAYERS  per-layer visible (0 = collected/disappeared)
- ovl_on  in  1  banner (logo/win/lose) pixel present
- ovl_rgb  in  12  banner pixel colour
- screen_mode  out  2  0 TITLE, 1 PLAY, 2 WIN, 3 LOSE
- draw_r  out  4  red
- draw_g  out  4  green
- draw_b  out  4  blue

Behaviour:
- Reset: screen_mode=TITLE, all pipeline registers 0, draw_r/g/b=0, pending flags clear, fade level 0.

Mode FSM and pending flags:
- Requests latch into pending flags on any cycle. The FSM updates only on a cycle with frame_start=1, then the flags clear.
- TITLE -> PLAY when start is pending.
- PLAY -> LOSE if lose is pending; otherwise PLAY -> WIN if win is pending. If both are pending, LOSE wins.
- WIN/LOSE -> TITLE when restart is pending. start is ignored in WIN/LOSE.
- Requests arriving in the same cycle as frame_start are taken that frame.
- Reset mid-frame returns immediately to TITLE and clears pending flags.

Stage 1 (registered):
- Per layer, hit_i = layer_en[i] & (draw_x>=lx) & (draw_x<=lx+SPR_W-1) & (draw_y>=ly) & (draw_y<=ly+SPR_H-1) & (layer_rgb_i != KEY_RGB).
- Sums are computed XW+1 / YW+1 bits wide, so sprites near the maximum coordinate do not wrap.
- Also registers: the colour of the lowest-index hit (priority encoder), any_hit, border flag (draw_x<=XMIN | draw_x>=XMAX | draw_y<=YMIN | draw_y>=YMAX), ovl_on, ovl_rgb.

Stage 2 (registered output), priority by mode:
- PLAY: sprite > border > PLAY_BG. Overlay is ignored.
- TITLE/WIN/LOSE: overlay > border > mode background. Sprites are suppressed.

Latency and throughput:
- Latency is exactly 2 clk_83 cycles from draw_x/draw_y to draw_r/g/b, at one pixel per cycle.
- screen_mode is used by stage 2 directly, so a mode change affects pixels output from the cycle after the commit.

Optional Feature:
- Macro: SPRITE_COMPOSITOR_FADE_EN.
- Enabled:
  - A 4-bit fade level resets to 0 on each committed mode change and increments by 1 per frame_start, saturating at 15.
  - Each output channel is (c*(fade+1))>>4, applied in a third register stage; latency becomes 3 cycles.
  - At fade=15 the output equals c.
- Disabled: no fade logic, latency 2, output is the unscaled colour.

Test Plan:
- Reset with rst=1 mid-PLAY -> screen_mode=0 and draw_rgb=0 immediately; after release, at pixel (500,400) in TITLE with ovl_on=0, output is 12'hFFF two cycles later.
- start=1 pulsed mid-frame -> screen_mode stays 0 until the next frame_start, becomes 1 the cycle after it; pixel (5,5) -> 12'h078 and (600,600) with no hit -> 12'hEEE.
- PLAY, layer 0 at (100,100) colour 12'hF00 overlapping layer 3 at (110,100) colour 12'h0F0:
  - pixel (115,110) -> 12'hF00
  - pixel (135,110) -> 12'h0F0
  - pixel (131,110) -> 12'hF00 (layer 0 covers x 100..131)
  - pixel (132,110) -> 12'h0F0
- Transparency and enable: layer 0 pixel = KEY_RGB over layer 1 colour 12'h00F -> 12'h00F; with layer_en[1]=0 -> 12'hEEE.
- win=1 and lose=1 both asserted before frame_start -> screen_mode=3, background 12'h000; restart pulse then frame_start -> screen_mode=0.
- Edge: layer at x=2040 (11-bit) -> no hit at draw_x=0..10. With SPRITE_COMPOSITOR_FADE_EN, after a commit to PLAY, a 12'hEEE background outputs 12'h000 at fade 0 and 12'hEEE at fade 15.

Source files
------------

// File: rtl/sprite_compositor.sv
// Sprite compositor: N sprite layers, overlay banner, border and
// per-mode background, plus the TITLE/PLAY/WIN/LOSE screen-mode FSM.
//
// Ports:
//   clk_83, rst (async, active-high)
//   frame_start: one-cycle pulse at pixel (0,0); mode commits here
//   start, restart, win, lose: mode requests, latched until frame_start
//   draw_x/draw_y: current pixel
//   layer_x/layer_y/layer_rgb/layer_en: packed per-layer sprite data
//   ovl_on/ovl_rgb: banner pixel
//   screen_mode: 0 TITLE, 1 PLAY, 2 WIN, 3 LOSE
//   draw_r/g/b: composited colour, 2 cycles after draw_x/draw_y
//
// Optional macro SPRITE_COMPOSITOR_FADE_EN adds a per-frame fade-in
// stage after each mode change (latency becomes 3 cycles).
module sprite_compositor #(
    parameter int          N_LAYERS   = 8,
    parameter int          XW         = 11,
    parameter int          YW         = 10,
    parameter int          SPR_W      = 32,
    parameter int          SPR_H      = 32,
    parameter logic [11:0] KEY_RGB    = 12'h000,
    parameter int          XMIN       = 10,
    parameter int          XMAX       = 1268,
    parameter int          YMIN       = 10,
    parameter int          YMAX       = 789,
    parameter logic [11:0] BORDER_RGB = 12'h078,
    parameter logic [11:0] PLAY_BG    = 12'hEEE,
    parameter logic [11:0] TITLE_BG   = 12'hFFF,
    parameter logic [11:0] WIN_BG     = 12'hFFF,
    parameter logic [11:0] LOSE_BG    = 12'h000
) (
    input  logic                   clk_83,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   start,
    input  logic                   restart,
    input  logic                   win,
    input  logic                   lose,
    input  logic [XW-1:0]          draw_x,
    input  logic [YW-1:0]          draw_y,
    input  logic [N_LAYERS*XW-1:0] layer_x,
    input  logic [N_LAYERS*YW-1:0] layer_y,
    input  logic [N_LAYERS*12-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]    layer_en,
    input  logic                   ovl_on,
    input  logic [11:0]            ovl_rgb,
    output logic [1:0]             screen_mode,
    output logic [3:0]             draw_r,
    output logic [3:0]             draw_g,
    output logic [3:0]             draw_b
);

    typedef enum logic [1:0] {
        S_TITLE = 2'd0,
        S_PLAY  = 2'd1,
        S_WIN   = 2'd2,
        S_LOSE  = 2'd3
    } mode_e;

    localparam logic [XW-1:0] LP_XMIN = XW'(XMIN);
    localparam logic [XW-1:0] LP_XMAX = XW'(XMAX);
    localparam logic [YW-1:0] LP_YMIN = YW'(YMIN);
    localparam logic [YW-1:0] LP_YMAX = YW'(YMAX);
    localparam logic [XW:0]   LP_XSPAN = (XW+1)'(SPR_W - 1);
    localparam logic [YW:0]   LP_YSPAN = (YW+1)'(SPR_H - 1);

    // ---------------- mode FSM ----------------
    mode_e r_mode;
    mode_e w_mode_nxt;
    logic  r_start_p;
    logic  r_restart_p;
    logic  r_win_p;
    logic  r_lose_p;
    logic  w_start_eff;
    logic  w_restart_eff;
    logic  w_win_eff;
    logic  w_lose_eff;

    // Requests seen in the frame_start cycle itself count for that frame.
    assign w_start_eff   = r_start_p | start;
    assign w_restart_eff = r_restart_p | restart;
    assign w_win_eff     = r_win_p | win;
    assign w_lose_eff    = r_lose_p | lose;

    always_ff @(posedge clk_83 or posedge rst) begin
        if (rst) begin
            r_start_p   <= 1'b0;
            r_restart_p <= 1'b0;
            r_win_p     <= 1'b0;
            r_lose_p    <= 1'b0;
        end else if (frame_start) begin
            r_start_p   <= 1'b0;
            r_restart_p <= 1'b0;
            r_win_p     <= 1'b0;
            r_lose_p    <= 1'b0;
        end else begin
            r_start_p   <= w_start_eff;
            r_restart_p <= w_restart_eff;
            r_win_p     <= w_win_eff;
            r_lose_p    <= w_lose_eff;
        end
    end

    always_ff @(posedge clk_83 or posedge rst) begin
        if (rst) r_mode <= S_TITLE;
        else     r_mode <= w_mode_nxt;
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (frame_start) begin
            case (r_mode)
                S_TITLE: if (w_start_eff) w_mode_nxt = S_PLAY;
                S_PLAY: begin
                    if (w_lose_eff)     w_mode_nxt = S_LOSE;
                    else if (w_win_eff) w_mode_nxt = S_WIN;
                end
                S_WIN:   if (w_restart_eff) w_mode_nxt = S_TITLE;
                S_LOSE:  if (w_restart_eff) w_mode_nxt = S_TITLE;
                default: w_mode_nxt = S_TITLE;
            endcase
        end
    end

    assign screen_mode = r_mode;

    // ---------------- stage 1: hit test ----------------
    logic [N_LAYERS-1:0] w_hit;

    for (genvar g = 0; g < N_LAYERS; g++) begin : g_hit
        logic [XW-1:0] w_lx;
        logic [YW-1:0] w_ly;
        logic [XW:0]   w_xe;
        logic [YW:0]   w_ye;
        logic [11:0]   w_rgb;
        assign w_lx  = layer_x[g*XW +: XW];
        assign w_ly  = layer_y[g*YW +: YW];
        assign w_rgb = layer_rgb[g*12 +: 12];
        // One extra bit keeps the right/bottom edge from wrapping.
        assign w_xe  = {1'b0, w_lx} + LP_XSPAN;
        assign w_ye  = {1'b0, w_ly} + LP_YSPAN;
        assign w_hit[g] = layer_en[g]
                        & (draw_x >= w_lx)
                        & ({1'b0, draw_x} <= w_xe)
                        & (draw_y >= w_ly)
                        & ({1'b0, draw_y} <= w_ye)
                        & (w_rgb != KEY_RGB);
    end

    logic [11:0] w_sel_rgb;
    logic        w_border;

    // Lowest index wins: scan downward so index 0 is written last.
    always_comb begin
        w_sel_rgb = 12'h000;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (w_hit[i]) w_sel_rgb = layer_rgb[i*12 +: 12];
        end
    end

    assign w_border = (draw_x <= LP_XMIN) | (draw_x >= LP_XMAX)
                    | (draw_y <= LP_YMIN) | (draw_y >= LP_YMAX);

    logic        r_s1_hit;
    logic [11:0] r_s1_rgb;
    logic        r_s1_border;
    logic        r_s1_ovl_on;
    logic [11:0] r_s1_ovl_rgb;

    always_ff @(posedge clk_83 or posedge rst) begin
        if (rst) begin
            r_s1_hit     <= 1'b0;
            r_s1_rgb     <= 12'h000;
            r_s1_border  <= 1'b0;
            r_s1_ovl_on  <= 1'b0;
            r_s1_ovl_rgb <= 12'h000;
        end else begin
            r_s1_hit     <= |w_hit;
            r_s1_rgb     <= w_sel_rgb;
            r_s1_border  <= w_border;
            r_s1_ovl_on  <= ovl_on;
            r_s1_ovl_rgb <= ovl_rgb;
        end
    end

    // ---------------- stage 2: mode priority ----------------
    logic [11:0] w_s2_rgb;
    logic [11:0] r_s2_rgb;

    always_comb begin
        w_s2_rgb = PLAY_BG;
        if (r_mode == S_PLAY) begin
            if (r_s1_hit)         w_s2_rgb = r_s1_rgb;
            else if (r_s1_border) w_s2_rgb = BORDER_RGB;
            else                  w_s2_rgb = PLAY_BG;
        end else if (r_s1_ovl_on) begin
            w_s2_rgb = r_s1_ovl_rgb;
        end else if (r_s1_border) begin
            w_s2_rgb = BORDER_RGB;
        end else begin
            case (r_mode)
                S_WIN:   w_s2_rgb = WIN_BG;
                S_LOSE:  w_s2_rgb = LOSE_BG;
                default: w_s2_rgb = TITLE_BG;
            endcase
        end
    end

    always_ff @(posedge clk_83 or posedge rst) begin
        if (rst) r_s2_rgb <= 12'h000;
        else     r_s2_rgb <= w_s2_rgb;
    end

    logic [11:0] w_out;

`ifdef SPRITE_COMPOSITOR_FADE_EN
    // ---------------- stage 3: fade-in ----------------
    logic [3:0]  r_fade;
    logic [11:0] r_s3_rgb;
    logic [3:0]  w_fr;
    logic [3:0]  w_fg;
    logic [3:0]  w_fb;

    always_ff @(posedge clk_83 or posedge rst) begin
        if (rst) begin
            r_fade <= 4'd0;
        end else if (frame_start) begin
            if (w_mode_nxt != r_mode) r_fade <= 4'd0;
            else if (r_fade != 4'hF)  r_fade <= r_fade + 4'd1;
        end
    end

    // c*(fade+1) peaks at 240, so 8 bits hold the product.
    assign w_fr = 4'((8'(r_s2_rgb[11:8]) * (8'(r_fade) + 8'd1)) >> 4);
    assign w_fg = 4'((8'(r_s2_rgb[7:4])  * (8'(r_fade) + 8'd1)) >> 4);
    assign w_fb = 4'((8'(r_s2_rgb[3:0])  * (8'(r_fade) + 8'd1)) >> 4);

    always_ff @(posedge clk_83 or posedge rst) begin
        if (rst) r_s3_rgb <= 12'h000;
        else     r_s3_rgb <= {w_fr, w_fg, w_fb};
    end

    assign w_out = r_s3_rgb;
`else
    assign w_out = r_s2_rgb;
`endif

    assign draw_r = w_out[11:8];
    assign draw_g = w_out[7:4];
    assign draw_b = w_out[3:0];

endmodule
